tmds_serializer_array: RTL and testbench

TMDS_SERIALIZER_ARRAY -- requirements
Module: tmds_serializer_array

---
 rtl/tmds_pkg.sv | 17 +
 rtl/symbol_fifo.sv | 65 ++++++
 rtl/tmds_serializer_array.sv | 158 +++++++++++++++
 tb/tb_tmds_serializer_array.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-period tokens C0..C3 and the serializer FSM state type.
package tmds_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ser_state_e;

  // Control tokens for {c1,c0} = 00, 01, 10, 11 during blanking
  localparam logic [9:0] TMDS_C0 = 10'b1101010100;
  localparam logic [9:0] TMDS_C1 = 10'b0010101011;
  localparam logic [9:0] TMDS_C2 = 10'b0101010100;
  localparam logic [9:0] TMDS_C3 = 10'b1010101011;

  localparam logic [9:0] TMDS_IDLE_SYMBOL = TMDS_C0;

endpackage

// File: rtl/symbol_fifo.sv
// Symbol-word FIFO with power-of-two depth, registered occupancy and combinational head read.
module symbol_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             ready_o,
  output logic [LW-1:0]    level_o
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Handshake qualification; a pop frees the slot a same-cycle push may use
  always_comb begin
    full_s    = (level_r == FULL_LVL);
    empty_s   = (level_r == {LW{1'b0}});
    pop_ok_s  = pop_i && !empty_s;
    push_ok_s = push_i && (!full_s || pop_ok_s);
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until the pointers say otherwise
  always_ff @(posedge clk_i) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata_i;
  end

  assign rdata_o = mem_r[rd_ptr_r];
  assign ready_o = !full_s;
  assign level_o = level_r;

endmodule

// File: rtl/tmds_serializer_array.sv
// Multi-lane TMDS symbol serializer: FIFO-fed, lockstep lanes, OUT_W bits per lane per clock.
// Optional build macro TMDS_SERIALIZER_ARRAY_UNDERFLOW_CNT_EN adds a saturating underflow counter.
module tmds_serializer_array
  import tmds_pkg::*;
#(
  parameter int                    CHANNELS    = 3,
  parameter int                    SYMBOL_W    = 10,
  parameter int                    OUT_W       = 2,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [SYMBOL_W-1:0]   IDLE_SYMBOL = TMDS_IDLE_SYMBOL
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           symbol_valid_i,
  output logic                           symbol_ready_o,
  input  logic [CHANNELS*SYMBOL_W-1:0]   symbol_i,
  input  logic                           enable_i,
  output logic [CHANNELS*OUT_W-1:0]      bits_o,
  output logic                           running_o,
  output logic                           underflow_o,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o
`ifdef TMDS_SERIALIZER_ARRAY_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]                    underflow_count_o
`endif
);

  localparam int WORD_W = CHANNELS * SYMBOL_W;
  localparam int BEATS  = SYMBOL_W / OUT_W;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
  localparam logic [BW-1:0]     BEAT_ONE  = BW'(1'b1);
  localparam logic [WORD_W-1:0] IDLE_WORD = {CHANNELS{IDLE_SYMBOL}};

  ser_state_e                 state_r;
  logic [BW-1:0]              beat_r;
  logic [WORD_W-1:0]          shift_r;
  logic [CHANNELS*OUT_W-1:0]  bits_r;
  logic                       running_r;
  logic                       underflow_r;

  logic [WORD_W-1:0]          fifo_head_s;
  logic [LW-1:0]              fifo_level_s;
  logic                       fifo_ready_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       subst_s;
  logic                       last_beat_s;
  logic [WORD_W-1:0]          shifted_s;
  logic [CHANNELS*OUT_W-1:0]  bits_next_s;

  assign push_s = symbol_valid_i && fifo_ready_s;

  symbol_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push_s),
    .pop_i     (pop_s),
    .wdata_i   (symbol_i),
    .rdata_o   (fifo_head_s),
    .ready_o   (fifo_ready_s),
    .level_o   (fifo_level_s)
  );

  // Symbol-boundary decisions and per-lane shift/output slicing
  always_comb begin
    last_beat_s = (beat_r == LAST_BEAT);
    shifted_s   = '0;
    bits_next_s = '0;
    if ((state_r == ST_RUN) && last_beat_s && enable_i) begin
      pop_s   = (fifo_level_s != {LW{1'b0}});
      subst_s = (fifo_level_s == {LW{1'b0}});
    end else begin
      pop_s   = 1'b0;
      subst_s = 1'b0;
    end
    for (int k = 0; k < CHANNELS; k++) begin
      shifted_s[k*SYMBOL_W +: SYMBOL_W] = shift_r[k*SYMBOL_W +: SYMBOL_W] >> OUT_W;
      bits_next_s[k*OUT_W +: OUT_W]     = shift_r[k*SYMBOL_W +: OUT_W];
    end
  end

  // Serializer FSM; enable is only honoured at a symbol boundary so symbols never truncate
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= ST_IDLE;
      beat_r      <= LAST_BEAT;
      shift_r     <= '0;
      bits_r      <= '0;
      running_r   <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      bits_r <= bits_next_s;
      case (state_r)
        ST_IDLE: begin
          shift_r <= '0;
          beat_r  <= LAST_BEAT;
          if (enable_i) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (last_beat_s) begin
            if (!enable_i) begin
              state_r   <= ST_IDLE;
              running_r <= 1'b0;
              shift_r   <= '0;
            end else if (subst_s) begin
              shift_r     <= IDLE_WORD;
              underflow_r <= 1'b1;
              beat_r      <= {BW{1'b0}};
            end else begin
              shift_r <= fifo_head_s;
              beat_r  <= {BW{1'b0}};
            end
          end else begin
            shift_r <= shifted_s;
            beat_r  <= beat_r + BEAT_ONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          running_r <= 1'b0;
          shift_r   <= '0;
          beat_r    <= LAST_BEAT;
        end
      endcase
    end
  end

`ifdef TMDS_SERIALIZER_ARRAY_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt_r;

  // Saturating count of substituted idle symbols
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      underflow_cnt_r <= 16'h0000;
    end else if (subst_s && (underflow_cnt_r != 16'hFFFF)) begin
      underflow_cnt_r <= underflow_cnt_r + 16'h0001;
    end
  end

  assign underflow_count_o = underflow_cnt_r;
`endif

  assign symbol_ready_o = fifo_ready_s;
  assign bits_o         = bits_r;
  assign running_o      = running_r;
  assign underflow_o    = underflow_r;
  assign fifo_level_o   = fifo_level_s;

endmodule

// File: tb/tb_tmds_serializer_array.sv
// Directed scoreboard bench for tmds_serializer_array (3 lanes, 10-bit symbols, 2 bits/clock, depth 4).
module tb_tmds_serializer_array;

  localparam int CH    = 3;
  localparam int SW    = 10;
  localparam int OW    = 2;
  localparam int DEPTH = 4;
  localparam int BEATS = 5;
  localparam int WW    = CH * SW;
  localparam logic [SW-1:0] IDLE_SYM = 10'b1101010100;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid;
  logic            enable;
  logic [WW-1:0]   symbol;
  logic            ready;
  logic            running;
  logic            underflow;
  logic [CH*OW-1:0] bits;
  logic [2:0]      level;
`ifdef TMDS_SERIALIZER_ARRAY_UNDERFLOW_CNT_EN
  logic [15:0]     uf_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [WW-1:0] sb_q[$];
  logic [WW-1:0] out_q[$];
  int mdl_level;

  tmds_serializer_array dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .symbol_valid_i (valid),
    .symbol_ready_o (ready),
    .symbol_i       (symbol),
    .enable_i       (enable),
    .bits_o         (bits),
    .running_o      (running),
    .underflow_o    (underflow),
    .fifo_level_o   (level)
`ifdef TMDS_SERIALIZER_ARRAY_UNDERFLOW_CNT_EN
    ,
    .underflow_count_o (uf_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [CH*OW-1:0] exp_bits(input logic [WW-1:0] w, input int b);
    logic [CH*OW-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) r[k*OW +: OW] = w[k*SW + b*OW +: OW];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    valid  = 1'b1;
    symbol = w;
    chk("push_ready", 32'(ready), 32'(mdl_level != DEPTH));
    tick();
    if (mdl_level != DEPTH) begin
      sb_q.push_back(w);
      mdl_level++;
    end
    valid = 1'b0;
    chk("push_level", 32'(level), 32'(mdl_level));
  endtask

  task automatic check_symbol(input logic [WW-1:0] w, input int drop_beat, input string tag);
    for (int b = 0; b < BEATS; b++) begin
      if (b > 0) tick();
      chk(tag, 32'(bits), 32'(exp_bits(w, b)));
      if (b == drop_beat) enable = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [WW-1:0] w;
    logic [WW-1:0] nxt;
    logic [WW-1:0] idle_word;
    logic          acc;
    logic          popm;
    logic          en_mdl;

    idle_word = {CH{IDLE_SYM}};
    rst_n = 1'b0; valid = 1'b0; enable = 1'b0; symbol = '0; mdl_level = 0;

    // Reset state
    #2;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_bits", 32'(bits), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single word: lane0 = 10'h2AB, check latency and LSB-first order
    w = {10'h155, 10'h0F0, 10'h2AB};
    push_word(w);
    enable = 1'b1;
    tick();
    chk("a_running", 32'(running), 32'd1);
    tick();
    chk("a_latency_bits", 32'(bits), 32'd0);
    w = sb_q.pop_front(); mdl_level--;
    chk("a_level", 32'(level), 32'(mdl_level));
    enable = 1'b0;
    tick();
    chk("a_lane0_b0", 32'(bits[1:0]), 32'd3);
    check_symbol(w, 5, "a_beat");
    chk("a_underflow", 32'(underflow), 32'd0);
    chk("a_running_off", 32'(running), 32'd0);
    tick();
    chk("a_bits_idle", 32'(bits), 32'd0);

    // Fill: five offers, only four accepted
    for (int i = 0; i < 5; i++) push_word(WW'($urandom));
    chk("b_level_full", 32'(level), 32'd4);
    chk("b_ready_full", 32'(ready), 32'd0);
    chk("b_sb_size", 32'(sb_q.size()), 32'd4);

    // Streaming from a full FIFO with valid held high, 20 symbols
    nxt = WW'($urandom);
    valid = 1'b1; symbol = nxt; enable = 1'b1; en_mdl = 1'b1;
    for (int n = 1; n <= 102; n++) begin
      acc  = (mdl_level != DEPTH);
      popm = (n >= 2) && (((n - 2) % 5) == 0) && en_mdl && (mdl_level > 0);
      chk("c_ready", 32'(ready), 32'(acc));
      tick();
      if (n >= 3) begin
        chk("c_beat", 32'(bits), 32'(exp_bits(out_q[0], (n - 3) % 5)));
        if (((n - 3) % 5) == 4) void'(out_q.pop_front());
      end
      if (popm) begin
        out_q.push_back(sb_q.pop_front());
        mdl_level--;
      end
      if (acc) begin
        sb_q.push_back(nxt);
        mdl_level++;
        nxt = WW'($urandom);
        symbol = nxt;
      end
      chk("c_level", 32'(level), 32'(mdl_level));
      if (n == 97) begin
        enable = 1'b0;
        en_mdl = 1'b0;
      end
    end
    valid = 1'b0;
    chk("c_running_off", 32'(running), 32'd0);
    chk("c_underflow", 32'(underflow), 32'd0);
    chk("c_out_drained", 32'(out_q.size()), 32'd0);
    tick();
    chk("c_bits_idle", 32'(bits), 32'd0);

    // Drop enable mid-symbol: the symbol completes, no extra pop
    enable = 1'b1;
    tick();
    chk("d_running", 32'(running), 32'd1);
    tick();
    w = sb_q.pop_front(); mdl_level--;
    chk("d_level", 32'(level), 32'(mdl_level));
    tick();
    check_symbol(w, 2, "d_beat");
    chk("d_running_off", 32'(running), 32'd0);
    chk("d_level_hold", 32'(level), 32'(mdl_level));
    tick();
    chk("d_bits_idle", 32'(bits), 32'd0);
    chk("d_level_hold2", 32'(level), 32'(mdl_level));

    // Reset mid-symbol discards output and FIFO
    enable = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("f_bits", 32'(bits), 32'd0);
    chk("f_level", 32'(level), 32'd0);
    chk("f_running", 32'(running), 32'd0);
    chk("f_ready", 32'(ready), 32'd1);
    sb_q.delete(); mdl_level = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Underflow: three idle symbols from an empty FIFO
    enable = 1'b1;
    tick();
    chk("e_running", 32'(running), 32'd1);
    tick();
    chk("e_underflow", 32'(underflow), 32'd1);
    tick();
    check_symbol(idle_word, 5, "e_idle1");
    tick();
    check_symbol(idle_word, 4, "e_idle2");
    tick();
    check_symbol(idle_word, 5, "e_idle3");
    tick();
    chk("e_running_off", 32'(running), 32'd0);
    chk("e_bits_idle", 32'(bits), 32'd0);
    chk("e_underflow_sticky", 32'(underflow), 32'd1);
    chk("e_level", 32'(level), 32'd0);
`ifdef TMDS_SERIALIZER_ARRAY_UNDERFLOW_CNT_EN
    chk("e_uf_count", 32'(uf_cnt), 32'd3);
`endif

    // Reset clears the sticky flag and the counter
    rst_n = 1'b0;
    #1;
    chk("g_underflow", 32'(underflow), 32'd0);
    chk("g_bits", 32'(bits), 32'd0);
`ifdef TMDS_SERIALIZER_ARRAY_UNDERFLOW_CNT_EN
    chk("g_uf_count", 32'(uf_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
